// File: rtl/rv_target_bfm_if.sv
// Target-side rv beat stream plus host-side pop stream of the rv target BFM.
// master = initiator/host environment, slave = the BFM.
interface rv_target_bfm_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] t_dat;
    logic             t_valid;
    logic             t_ready;
    logic [WIDTH-1:0] pop_dat;
    logic             pop_valid;
    logic             pop_ready;

    modport master (
        output t_dat, t_valid, pop_ready,
        input  t_ready, pop_dat, pop_valid
    );

    modport slave (
        input  t_dat, t_valid, pop_ready,
        output t_ready, pop_dat, pop_valid
    );
endinterface

// File: rtl/rv_target_bfm.sv
// rv target BFM: accepts beats under a programmable backpressure policy into a show-ahead FIFO.
// Optional RANDOM policy LFSR enabled by macro RV_TARGET_BFM_LFSR_EN (otherwise RANDOM == ALWAYS).
module rv_target_bfm #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    rv_target_bfm_if.slave bus,
    input  logic [1:0]  cfg_mode,
    input  logic [7:0]  cfg_period,
    output logic [31:0] xfer_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] MODE_ALWAYS   = 2'd0;
    localparam logic [1:0] MODE_PERIODIC = 2'd1;
    localparam logic [1:0] MODE_RANDOM   = 2'd2;
    localparam logic [1:0] MODE_NEVER    = 2'd3;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             t_ready_q, t_ready_d;
    logic             pop_valid_q, pop_valid_d;
    logic [7:0]       per_cnt_q, per_cnt_d;
    logic [1:0]       mode_q;
    logic [31:0]      xfer_q, xfer_d;
    logic             push, pop, policy_ok;

`ifdef RV_TARGET_BFM_LFSR_EN
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    logic [31:0] lfsr_q, lfsr_d;
    assign lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
`endif

    assign push = bus.t_valid && t_ready_q;
    assign pop  = pop_valid_q && bus.pop_ready;

    assign wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    assign rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    assign xfer_d      = push ? xfer_q + 32'd1 : xfer_q;
    assign pop_valid_d = (count_d != '0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Counter idles at 0 outside PERIODIC and restarts whenever the mode changes.
    always_comb begin
        per_cnt_d = 8'd0;
        if (cfg_mode == MODE_PERIODIC && mode_q == MODE_PERIODIC && per_cnt_q < cfg_period) begin
            per_cnt_d = per_cnt_q + 8'd1;
        end
    end

    always_comb begin
        policy_ok = 1'b1;
        case (cfg_mode)
            MODE_ALWAYS:   policy_ok = 1'b1;
            MODE_PERIODIC: policy_ok = (per_cnt_d == cfg_period);
`ifdef RV_TARGET_BFM_LFSR_EN
            MODE_RANDOM:   policy_ok = lfsr_q[0];
`else
            MODE_RANDOM:   policy_ok = 1'b1;
`endif
            MODE_NEVER:    policy_ok = 1'b0;
            default:       policy_ok = 1'b1;
        endcase
    end

    // Ready looks ahead at this cycle's push/pop so the FIFO can never overflow.
    assign t_ready_d = policy_ok && (count_d < DEPTH_C);

    always_ff @(posedge clock) begin
        mode_q <= cfg_mode;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            t_ready_q   <= 1'b0;
            pop_valid_q <= 1'b0;
            per_cnt_q   <= 8'd0;
            xfer_q      <= 32'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= bus.t_dat;
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            t_ready_q   <= t_ready_d;
            pop_valid_q <= pop_valid_d;
            per_cnt_q   <= per_cnt_d;
            xfer_q      <= xfer_d;
        end
    end

`ifdef RV_TARGET_BFM_LFSR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= 32'hACE1_2345;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    assign bus.t_ready   = t_ready_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.pop_dat   = mem_q[rd_ptr_q];
    assign xfer_count    = xfer_q;
endmodule

// File: tb/tb_rv_target_bfm.sv
// Directed bench for rv_target_bfm: reset, each backpressure policy, full FIFO, mid-run reset.
module tb_rv_target_bfm;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cfg_mode = 2'd0;
    logic [7:0]  cfg_period = 8'd0;
    logic [31:0] xfer_count;

    rv_target_bfm_if #(.WIDTH(32)) bus ();

    rv_target_bfm #(.WIDTH(32), .DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .xfer_count (xfer_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [31:0] beats[$];
    logic [31:0] rx_q[$];
    int send_idx;
    int rdy_cnt;

    task automatic drive_tx();
        if (send_idx < beats.size()) begin
            bus.t_valid = 1'b1;
            bus.t_dat   = beats[send_idx];
        end else begin
            bus.t_valid = 1'b0;
            bus.t_dat   = '0;
        end
    endtask

    // One clock: record the handshakes visible before the edge, then advance the initiator.
    task automatic cycle();
        logic acc, pp;
        acc = bus.t_valid && bus.t_ready;
        pp  = bus.pop_valid && bus.pop_ready;
        if (pp) rx_q.push_back(bus.pop_dat);
        if (bus.t_ready) rdy_cnt++;
        @(posedge clock);
        #1;
        if (acc) send_idx++;
        drive_tx();
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.t_valid   = 1'b0;
        bus.t_dat     = '0;
        bus.pop_ready = 1'b0;
        beats.delete();
        rx_q.delete();
        send_idx = 0;
        rdy_cnt  = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        cfg_mode = 2'd0;
        do_reset();
        checks++; if (bus.t_ready !== 1'b0) begin errors++; $display("FAIL reset_t_ready: got %b want 0", bus.t_ready); end
        checks++; if (bus.pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid: got %b want 0", bus.pop_valid); end
        checks++; if (bus.pop_dat !== 32'h0) begin errors++; $display("FAIL reset_pop_dat: got %h want 0", bus.pop_dat); end
        checks++; if (xfer_count !== 32'h0) begin errors++; $display("FAIL reset_xfer: got %0d want 0", xfer_count); end
        cycle();
        checks++; if (bus.t_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_resume: got %b want 1", bus.t_ready); end
    endtask

    task automatic test_always();
        cfg_mode = 2'd0;
        do_reset();
        bus.pop_ready = 1'b1;
        for (int i = 0; i < 8; i++) beats.push_back(32'(i + 1));
        drive_tx();
        cycle();
        checks++; if (bus.t_ready !== 1'b1 || bus.pop_valid !== 1'b0) begin errors++; $display("FAIL always_cycle1: ready=%b pop_valid=%b want 1/0", bus.t_ready, bus.pop_valid); end
        cycle();
        checks++; if (bus.pop_valid !== 1'b1 || bus.pop_dat !== 32'h1) begin errors++; $display("FAIL always_first_data: pop_valid=%b dat=%h want 1/1", bus.pop_valid, bus.pop_dat); end
        for (int k = 0; k < 100 && rx_q.size() < 8; k++) cycle();
        checks++; if (rx_q.size() != 8) begin errors++; $display("FAIL always_rx_count: got %0d want 8", rx_q.size()); end
        for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== 32'(i + 1)) begin errors++; $display("FAIL always_rx[%0d]: got %h want %h", i, rx_q[i], i + 1); end
        end
        checks++; if (xfer_count !== 32'd8) begin errors++; $display("FAIL always_xfer: got %0d want 8", xfer_count); end
    endtask

    task automatic test_full();
        cfg_mode = 2'd0;
        do_reset();
        for (int i = 0; i < 6; i++) beats.push_back(32'h11 + 32'(i));
        drive_tx();
        repeat (15) cycle();
        checks++; if (xfer_count !== 32'd4) begin errors++; $display("FAIL full_xfer: got %0d want 4", xfer_count); end
        checks++; if (bus.t_ready !== 1'b0) begin errors++; $display("FAIL full_t_ready: got %b want 0", bus.t_ready); end
        checks++; if (bus.pop_valid !== 1'b1 || bus.pop_dat !== 32'h11) begin errors++; $display("FAIL full_head: valid=%b dat=%h want 1/11", bus.pop_valid, bus.pop_dat); end
        bus.pop_ready = 1'b1;
        for (int k = 0; k < 50 && rx_q.size() < 6; k++) cycle();
        checks++; if (xfer_count !== 32'd6) begin errors++; $display("FAIL full_xfer_after: got %0d want 6", xfer_count); end
        checks++; if (rx_q.size() != 6) begin errors++; $display("FAIL full_rx_count: got %0d want 6", rx_q.size()); end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== 32'h11 + 32'(i)) begin errors++; $display("FAIL full_rx[%0d]: got %h want %h", i, rx_q[i], 32'h11 + i); end
        end
    endtask

    task automatic test_periodic();
        cfg_mode   = 2'd1;
        cfg_period = 8'd3;
        do_reset();
        bus.pop_ready = 1'b1;
        for (int i = 0; i < 8; i++) beats.push_back(32'h41 + 32'(i));
        drive_tx();
        repeat (20) cycle();
        checks++; if (xfer_count !== 32'd5) begin errors++; $display("FAIL periodic_xfer: got %0d want 5", xfer_count); end
        checks++; if (rdy_cnt != 5) begin errors++; $display("FAIL periodic_ready_slots: got %0d want 5", rdy_cnt); end
        checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL periodic_rx_count: got %0d want 4", rx_q.size()); end
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== 32'h41 + 32'(i)) begin errors++; $display("FAIL periodic_rx[%0d]: got %h want %h", i, rx_q[i], 32'h41 + i); end
        end
        cfg_period = 8'd0;
    endtask

    task automatic test_never();
        cfg_mode = 2'd3;
        do_reset();
        bus.pop_ready = 1'b1;
        beats.push_back(32'hA5);
        drive_tx();
        repeat (10) cycle();
        checks++; if (xfer_count !== 32'd0 || rdy_cnt != 0) begin errors++; $display("FAIL never_no_accept: xfer=%0d ready_cycles=%0d want 0/0", xfer_count, rdy_cnt); end
        checks++; if (bus.pop_valid !== 1'b0) begin errors++; $display("FAIL never_pop_valid: got %b want 0", bus.pop_valid); end
        cfg_mode = 2'd0;
        cycle();
        checks++; if (bus.t_ready !== 1'b1 || xfer_count !== 32'd0) begin errors++; $display("FAIL never_switch: ready=%b xfer=%0d want 1/0", bus.t_ready, xfer_count); end
        cycle();
        checks++; if (xfer_count !== 32'd1) begin errors++; $display("FAIL never_accept: got %0d want 1", xfer_count); end
        checks++; if (bus.pop_valid !== 1'b1 || bus.pop_dat !== 32'hA5) begin errors++; $display("FAIL never_data: valid=%b dat=%h want 1/a5", bus.pop_valid, bus.pop_dat); end
    endtask

    task automatic test_reset_mid();
        cfg_mode = 2'd0;
        do_reset();
        beats.push_back(32'h31);
        beats.push_back(32'h32);
        beats.push_back(32'h33);
        drive_tx();
        for (int k = 0; k < 20 && send_idx < 3; k++) cycle();
        checks++; if (xfer_count !== 32'd3 || bus.pop_valid !== 1'b1) begin errors++; $display("FAIL mid_fill: xfer=%0d valid=%b want 3/1", xfer_count, bus.pop_valid); end
        reset       = 1'b1;
        bus.t_valid = 1'b1;
        bus.t_dat   = 32'hEE;
        @(posedge clock);
        #1;
        reset = 1'b0;
        beats.delete();
        send_idx = 0;
        drive_tx();
        checks++; if (bus.pop_valid !== 1'b0 || xfer_count !== 32'd0 || bus.t_ready !== 1'b0) begin errors++; $display("FAIL mid_reset: valid=%b xfer=%0d ready=%b want 0/0/0", bus.pop_valid, xfer_count, bus.t_ready); end
        bus.pop_ready = 1'b1;
        repeat (5) cycle();
        checks++; if (rx_q.size() != 0 || xfer_count !== 32'd0) begin errors++; $display("FAIL mid_discard: popped=%0d xfer=%0d want 0/0", rx_q.size(), xfer_count); end
        checks++; if (bus.t_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_resume: got %b want 1", bus.t_ready); end
    endtask

    task automatic test_random();
        int bad;
        cfg_mode = 2'd2;
        do_reset();
        bus.pop_ready = 1'b1;
        for (int i = 0; i < 1000; i++) beats.push_back(32'(i + 1));
        drive_tx();
        repeat (1000) cycle();
`ifdef RV_TARGET_BFM_LFSR_EN
        checks++; if (rdy_cnt < 400 || rdy_cnt > 600) begin errors++; $display("FAIL random_duty: got %0d ready cycles want 400..600", rdy_cnt); end
`else
        checks++; if (rdy_cnt != 999) begin errors++; $display("FAIL random_as_always: got %0d ready cycles want 999", rdy_cnt); end
        checks++; if (xfer_count !== 32'd999) begin errors++; $display("FAIL random_as_always_xfer: got %0d want 999", xfer_count); end
`endif
        checks++; if (xfer_count !== 32'(send_idx)) begin errors++; $display("FAIL random_xfer: got %0d want %0d", xfer_count, send_idx); end
        bad = 0;
        for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== 32'(i + 1)) bad++;
        checks++; if (bad != 0 || rx_q.size() < 300) begin errors++; $display("FAIL random_order: %0d misordered of %0d popped", bad, rx_q.size()); end
    endtask

    initial begin
        bus.t_valid   = 1'b0;
        bus.t_dat     = '0;
        bus.pop_ready = 1'b0;
        test_reset();
        test_always();
        test_full();
        test_periodic();
        test_never();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
